collatz_engine: RTL and testbench

//  Parametrised Collatz trajectory engine; successor to the fixed 16-bit collatz top.

---
 rtl/collatz_engine_pkg.sv | 17 +
 rtl/collatz_engine_if.sv | 24 ++
 rtl/collatz_engine_step.sv | 27 ++
 rtl/collatz_engine.sv | 100 ++++++++++
 tb/tb_collatz_engine.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/collatz_engine_pkg.sv
// Shared types for the Collatz trajectory engine: FSM state and result status codes.
package collatz_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_ZERO_IN  = 2'd1,
    ST_OVERFLOW = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_e;

endpackage

// File: rtl/collatz_engine_if.sv
// Start-value and result handshakes of the Collatz engine.
interface collatz_engine_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] out_steps;
  logic [WIDTH-1:0]     out_peak;
  logic [1:0]           out_status;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_steps, out_peak, out_status
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_steps, out_peak, out_status
  );
endinterface

// File: rtl/collatz_engine_step.sv
// One combinational Collatz step: halve when even, 3x+1 when odd with carry-out detection.
module collatz_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] nx,
  output logic             ovf,
  output logic             is_one
);
  logic [WIDTH+1:0] x_ext;
  logic [WIDTH+1:0] tri_x;

  assign x_ext  = {2'b00, x};
  // 3x+1 as (x<<1)+x+1; two guard bits catch any result that no longer fits WIDTH
  assign tri_x  = (x_ext << 1) + x_ext + (WIDTH+2)'(1);
  assign is_one = (x == WIDTH'(1));

  // Select the successor and flag a carry out of the WIDTH-bit trajectory register
  always_comb begin
    nx  = x >> 1;
    ovf = 1'b0;
    if (x[0]) begin
      nx  = tri_x[WIDTH-1:0];
      ovf = |tri_x[WIDTH+1:WIDTH];
    end
  end
endmodule

// File: rtl/collatz_engine.sv
// Collatz trajectory engine: accepts N, iterates one step per clock, reports steps/peak/status.
module collatz_engine
  import collatz_engine_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16,
  parameter int MAX_STEPS = 65535
) (
  input  logic             clk,
  input  logic             nrst,
  collatz_engine_if.slave  bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(MAX_STEPS);

  state_e               state_q, state_d;
  status_e              status_q, status_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     peak_q, peak_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]     step_nx;
  logic                 step_ovf;
  logic                 step_one;

  collatz_step #(.WIDTH(WIDTH)) u_step (
    .x      (x_q),
    .nx     (step_nx),
    .ovf    (step_ovf),
    .is_one (step_one)
  );

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_steps  = cnt_q;
  assign bus.out_peak   = peak_q;
  assign bus.out_status = status_q;

  // State and datapath registers; reset abandons any run in progress
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      status_q <= ST_OK;
      x_q      <= '0;
      peak_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      x_q      <= x_d;
      peak_q   <= peak_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: accept in IDLE, step in RUN (1 > limit > overflow > advance), hold in DONE
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    x_d      = x_q;
    peak_d   = peak_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_d    = bus.in_data;
          peak_d = bus.in_data;
          cnt_d  = '0;
          if (bus.in_data == '0) begin
            status_d = ST_ZERO_IN;
            state_d  = ST_DONE;
          end else begin
            status_d = ST_OK;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (step_one) begin
          status_d = ST_OK;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          status_d = ST_TIMEOUT;
          state_d  = ST_DONE;
        end else if (step_ovf) begin
          // x and cnt keep the last representable point of the trajectory
          status_d = ST_OVERFLOW;
          state_d  = ST_DONE;
        end else begin
          x_d   = step_nx;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (step_nx > peak_q) peak_d = step_nx;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_collatz_engine.sv
// Directed bench for collatz_engine: three instances (16-bit, 8-bit, MAX_STEPS=50) and a result scoreboard.
module tb_collatz_engine;
  import collatz_engine_pkg::*;

  typedef struct packed {
    logic [15:0] steps;
    logic [15:0] peak;
    logic [1:0]  status;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  collatz_engine_if #(.WIDTH(16), .CNT_WIDTH(16)) a ();
  collatz_engine_if #(.WIDTH(8),  .CNT_WIDTH(16)) b ();
  collatz_engine_if #(.WIDTH(16), .CNT_WIDTH(16)) c ();

  collatz_engine #(.WIDTH(16), .CNT_WIDTH(16), .MAX_STEPS(65535)) u_a (
    .clk(clk), .nrst(nrst), .bus(a.slave));
  collatz_engine #(.WIDTH(8), .CNT_WIDTH(16), .MAX_STEPS(65535)) u_b (
    .clk(clk), .nrst(nrst), .bus(b.slave));
  collatz_engine #(.WIDTH(16), .CNT_WIDTH(16), .MAX_STEPS(50)) u_c (
    .clk(clk), .nrst(nrst), .bus(c.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference trajectory walk on wide integers
  function automatic exp_t model(input int unsigned n, input int w, input int maxs);
    exp_t            e;
    longint unsigned x, nx, pk;
    int              cnt;
    logic [1:0]      st;
    x = n; pk = n; cnt = 0; st = 2'd0;
    if (n == 0) begin
      e.steps = '0; e.peak = '0; e.status = 2'd1;
      return e;
    end
    while (1) begin
      if (x == 1) begin st = 2'd0; break; end
      if (cnt == maxs) begin st = 2'd3; break; end
      if (x % 2 == 0) nx = x / 2;
      else begin
        nx = 3 * x + 1;
        if (nx >= (64'd1 << w)) begin st = 2'd2; break; end
      end
      x = nx; cnt++;
      if (x > pk) pk = x;
    end
    e.steps = 16'(cnt); e.peak = 16'(pk); e.status = st;
    return e;
  endfunction

  task automatic pop_cmp(input string tag, input logic [15:0] s, input logic [15:0] p,
                         input logic [1:0] st, output exp_t e);
    e = '0;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_steps"},  32'(s),  32'(e.steps));
      check({tag, "_peak"},   32'(p),  32'(e.peak));
      check({tag, "_status"}, 32'(st), 32'(e.status));
    end
  endtask

  // Offer n on instance a, measure edges to out_valid, score the result, then consume it
  task automatic run_a(input string tag, input logic [15:0] n, input exp_t e, input int exp_edges);
    int   edges;
    exp_t got;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(a.in_ready), 32'd1);
    a.in_valid = 1'b1; a.in_data = n;
    sb.push_back(e);
    @(posedge clk); #1;
    a.in_valid = 1'b0;
    edges = 1;
    while (!a.out_valid && edges < 3000) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    pop_cmp(tag, a.out_steps, a.out_peak, a.out_status, got);
    @(negedge clk); a.out_ready = 1'b1;
    @(posedge clk); #1; a.out_ready = 1'b0;
    check({tag, "_released"}, 32'(a.out_valid), 32'd0);
  endtask

  initial begin
    exp_t e, got;
    int   edges;
    logic [15:0] rn;

    nrst = 1'b0;
    a.in_valid = 0; a.in_data = '0; a.out_ready = 0;
    b.in_valid = 0; b.in_data = '0; b.out_ready = 0;
    c.in_valid = 0; c.in_data = '0; c.out_ready = 0;
    #13;
    check("rst_in_ready",   32'(a.in_ready),   32'd1);
    check("rst_out_valid",  32'(a.out_valid),  32'd0);
    check("rst_out_steps",  32'(a.out_steps),  32'd0);
    check("rst_out_peak",   32'(a.out_peak),   32'd0);
    check("rst_out_status", 32'(a.out_status), 32'd0);
    #10 nrst = 1'b1;

    // N=1 with out_ready already high while idle (no effect)
    a.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_out_ready_noeffect", 32'(a.out_valid), 32'd0);
    a.out_ready = 1'b0;
    run_a("n1", 16'd1, '{16'd0, 16'd1, 2'd0}, 2);

    run_a("n27", 16'd27, '{16'd111, 16'd9232, 2'd0}, 113);
    run_a("n0", 16'd0, '{16'd0, 16'd0, 2'd1}, 1);

    // 8-bit instance overflows at 3*107+1
    @(negedge clk);
    b.in_valid = 1'b1; b.in_data = 8'd27;
    sb.push_back('{16'd11, 16'd214, 2'd2});
    @(posedge clk); #1; b.in_valid = 1'b0;
    edges = 1;
    while (!b.out_valid && edges < 3000) begin @(posedge clk); #1; edges++; end
    check("ovf8_latency", 32'(edges), 32'd13);
    pop_cmp("ovf8", b.out_steps, 16'(b.out_peak), b.out_status, got);
    @(negedge clk); b.out_ready = 1'b1;
    @(posedge clk); #1; b.out_ready = 1'b0;

    // MAX_STEPS=50 instance times out, then the result is held under backpressure
    @(negedge clk);
    c.in_valid = 1'b1; c.in_data = 16'd27;
    e = model(27, 16, 50);
    e.steps = 16'd50; e.status = 2'd3;
    sb.push_back(e);
    @(posedge clk); #1; c.in_valid = 1'b0;
    edges = 1;
    while (!c.out_valid && edges < 3000) begin @(posedge clk); #1; edges++; end
    check("tmo_latency", 32'(edges), 32'd52);
    pop_cmp("tmo", c.out_steps, c.out_peak, c.out_status, got);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("tmo_hold_valid",  32'(c.out_valid),  32'd1);
      check("tmo_hold_ready",  32'(c.in_ready),   32'd0);
      check("tmo_hold_steps",  32'(c.out_steps),  32'd50);
      check("tmo_hold_status", 32'(c.out_status), 32'd3);
      check("tmo_hold_peak",   32'(c.out_peak),   32'(got.peak));
    end
    @(negedge clk); c.out_ready = 1'b1;
    @(posedge clk); #1; c.out_ready = 1'b0;
    check("tmo_released", 32'(c.out_valid), 32'd0);
    check("tmo_idle",     32'(c.in_ready),  32'd1);

    // Reset in the middle of a run of N=7
    @(negedge clk);
    a.in_valid = 1'b1; a.in_data = 16'd7;
    @(posedge clk); #1; a.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); nrst = 1'b0;
    #1;
    check("midrst_in_ready",  32'(a.in_ready),  32'd1);
    check("midrst_out_valid", 32'(a.out_valid), 32'd0);
    check("midrst_steps",     32'(a.out_steps), 32'd0);
    #2 nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("midrst_no_output", 32'(a.out_valid), 32'd0);
    run_a("n7", 16'd7, '{16'd16, 16'd52, 2'd0}, 18);

    // Back-to-back N=6 then N=7 with in_valid held throughout
    @(negedge clk);
    a.out_ready = 1'b1;
    a.in_valid = 1'b1; a.in_data = 16'd6;
    sb.push_back('{16'd8, 16'd16, 2'd0});
    @(posedge clk); #1;
    a.in_data = 16'd7;
    sb.push_back('{16'd16, 16'd52, 2'd0});
    edges = 1;
    while (!a.out_valid && edges < 3000) begin
      check("b2b_busy_ready", 32'(a.in_ready), 32'd0);
      @(posedge clk); #1; edges++;
    end
    check("b2b6_latency", 32'(edges), 32'd10);
    pop_cmp("b2b6", a.out_steps, a.out_peak, a.out_status, got);
    @(posedge clk); #1;
    check("b2b_handshake_idle", 32'(a.in_ready),  32'd1);
    check("b2b_handshake_ov",   32'(a.out_valid), 32'd0);
    @(posedge clk); #1;
    check("b2b7_accepted", 32'(a.in_ready), 32'd0);
    a.in_valid = 1'b0;
    edges = 1;
    while (!a.out_valid && edges < 3000) begin @(posedge clk); #1; edges++; end
    check("b2b7_latency", 32'(edges), 32'd18);
    pop_cmp("b2b7", a.out_steps, a.out_peak, a.out_status, got);
    @(posedge clk); #1; a.out_ready = 1'b0;

    // A few pseudo-random start values scored against the reference walk
    for (int k = 0; k < 4; k++) begin
      rn = 16'($urandom_range(2, 3000));
      e = model(rn, 16, 65535);
      run_a("rand", rn, e, int'(e.steps) + 2);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
